// File: rtl/card_draw_ctrl.sv
// Card dealer: a 52-card deck with a used mask, random or fixed pick, linear scan and round-robin player/dealer grants.
// Build option: define CARD_DRAW_FIXED_EN to deal in lowest-unused-index order instead of LFSR-random order.
module card_draw_ctrl #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       shuffle,
   input  logic       player_req,
   input  logic       dealer_req,
   output logic       player_ack,
   output logic       dealer_ack,
   output logic [3:0] card_value,
   output logic [1:0] card_symbol,
   output logic [5:0] cards_left,
   output logic       deck_empty,
   output logic       busy,
   output logic [2:0] fsm_state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      PICK  = 3'd2,
      SCAN  = 3'd3,
      GRANT = 3'd4
   } state_t;

   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [5:0]  DECK = 6'd52;

   // Handshake: a requester holds its req level until it sees its one-cycle ack;
   // card outputs are valid in the ack cycle and hold until the next grant.
   state_t      state, state_nxt;
   logic [15:0] lfsr;
   logic [51:0] used;
   logic [63:0] used_ext;
   logic [5:0]  idx, idx_nxt;
   logic        winner_p, winner_nxt;
   logic        last_p;
   logic        load_card;
   logic [1:0]  sym_nxt;
   logic [5:0]  base_nxt;
   logic [5:0]  rank_nxt;
`ifndef CARD_DRAW_FIXED_EN
   logic [5:0]  cand;
   assign cand = lfsr[5:0];
`endif

   assign used_ext = {12'h000, used};

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      winner_nxt = winner_p;
      load_card  = 1'b0;
      case (state)
         IDLE: begin
            if (shuffle) begin
               state_nxt = CLEAR;
            end else if ((player_req || dealer_req) && (cards_left != 6'd0)) begin
               state_nxt  = PICK;
               // On a tie the side not granted last time wins.
               winner_nxt = player_req && (!dealer_req || !last_p);
            end
         end
         CLEAR: state_nxt = IDLE;
         PICK: begin
`ifdef CARD_DRAW_FIXED_EN
            state_nxt = SCAN;
            idx_nxt   = 6'd0;
`else
            if ((cand < DECK) && !used_ext[cand]) begin
               state_nxt = GRANT;
               idx_nxt   = cand;
               load_card = 1'b1;
            end else begin
               state_nxt = SCAN;
               idx_nxt   = (cand < DECK) ? cand : (cand - DECK);
            end
`endif
         end
         SCAN: begin
            if (!used_ext[idx]) begin
               state_nxt = GRANT;
               load_card = 1'b1;
            end else begin
               idx_nxt = (idx == 6'd51) ? 6'd0 : (idx + 6'd1);
            end
         end
         GRANT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Rank/suit split of the index being granted, without a divider.
   always_comb begin
      sym_nxt  = 2'd0;
      base_nxt = 6'd0;
      if (idx_nxt >= 6'd39) begin
         sym_nxt  = 2'd3;
         base_nxt = 6'd39;
      end else if (idx_nxt >= 6'd26) begin
         sym_nxt  = 2'd2;
         base_nxt = 6'd26;
      end else if (idx_nxt >= 6'd13) begin
         sym_nxt  = 2'd1;
         base_nxt = 6'd13;
      end
      rank_nxt = idx_nxt - base_nxt + 6'd1;
   end

   // The card is committed on entry to GRANT so that outputs, mask and count
   // are already consistent in the ack cycle; a reset before then leaves no trace.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         lfsr        <= SEED;
         used        <= 52'd0;
         cards_left  <= DECK;
         card_value  <= 4'd0;
         card_symbol <= 2'd0;
         idx         <= 6'd0;
         winner_p    <= 1'b0;
         last_p      <= 1'b0;
      end else begin
         lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         state    <= state_nxt;
         idx      <= idx_nxt;
         winner_p <= winner_nxt;
         if (state == CLEAR) begin
            used       <= 52'd0;
            cards_left <= DECK;
         end
         if (load_card) begin
            used        <= used | (52'd1 << idx_nxt);
            cards_left  <= cards_left - 6'd1;
            card_value  <= rank_nxt[3:0];
            card_symbol <= sym_nxt;
         end
         if (state == GRANT) begin
            last_p <= winner_p;
         end
      end
   end

   assign player_ack = (state == GRANT) && winner_p;
   assign dealer_ack = (state == GRANT) && !winner_p;
   assign busy       = (state != IDLE);
   assign deck_empty = (cards_left == 6'd0);
   assign fsm_state  = state;

endmodule

// File: tb/tb_card_draw_ctrl.sv
// Bench for card_draw_ctrl: random draws checked against a deck/LFSR reference model, plus reset, tie, empty and abort scenarios.
module tb_card_draw_ctrl;

   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       rst;
   logic       shuffle;
   logic       player_req;
   logic       dealer_req;
   logic       player_ack;
   logic       dealer_ack;
   logic [3:0] card_value;
   logic [1:0] card_symbol;
   logic [5:0] cards_left;
   logic       deck_empty;
   logic       busy;
   logic [2:0] fsm_state;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [15:0] m_lfsr;
   logic        m_used [52];
   logic        m_seen [52];
   int          m_left;
   logic        m_last_p;
   logic [5:0]  exp_q [$];

   card_draw_ctrl #(.LFSR_SEED(SEED)) dut (
      .clk         (clk),
      .rst         (rst),
      .shuffle     (shuffle),
      .player_req  (player_req),
      .dealer_req  (dealer_req),
      .player_ack  (player_ack),
      .dealer_ack  (dealer_ack),
      .card_value  (card_value),
      .card_symbol (card_symbol),
      .cards_left  (cards_left),
      .deck_empty  (deck_empty),
      .busy        (busy),
      .fsm_state   (fsm_state)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] x);
      return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
   endfunction

   // free-running generator, restarted from the seed by reset
   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= SEED;
      else     m_lfsr <= lfsr_step(m_lfsr);
   end

   function automatic int first_free(input int s);
      for (int n = 0; n < 52; n++) begin
         if (!m_used[(s + n) % 52]) return (s + n) % 52;
      end
      return -1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 52; i++) begin
         m_used[i] = 1'b0;
         m_seen[i] = 1'b0;
      end
      m_left = 52;
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      shuffle = 1'b0;
      player_req = 1'b0;
      dealer_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_clear();
      m_last_p = 1'b0;
   endtask

   // Called at a negedge with the DUT idle; raises the requests and follows the draw to its ack.
   task automatic do_draw(input logic rp, input logic rd, input logic drop);
      logic       exp_p;
      int         c, s, idx, d, exp_k, k, got_idx;
      logic       got;
      logic [5:0] exp_idx;
      logic [3:0] held_val;
      logic [1:0] held_sym;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL draw_idle_busy: got %0b want 0", busy);
      end
      player_req = rp;
      dealer_req = rd;
      exp_p = (rp && rd) ? !m_last_p : rp;
      @(negedge clk);
      c = int'(m_lfsr[5:0]);
`ifdef CARD_DRAW_FIXED_EN
      idx   = first_free(0);
      exp_k = 2 + idx;
`else
      if (c < 52 && !m_used[c]) begin
         idx   = c;
         exp_k = 1;
      end else begin
         s     = (c < 52) ? c : c - 52;
         idx   = first_free(s);
         d     = (idx - s + 52) % 52;
         exp_k = 2 + d;
      end
`endif
      exp_q.push_back(6'(idx));
      if (drop) begin
         player_req = 1'b0;
         dealer_req = 1'b0;
      end
      k = 0;
      got = 1'b0;
      while (!got && k < 60) begin
         @(negedge clk);
         k++;
         total++;
         if (player_ack && dealer_ack) begin
            bad++;
            $display("FAIL ack_overlap: got both acks high, want at most one");
         end
         if (player_ack || dealer_ack) got = 1'b1;
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL draw_timeout: got no ack within %0d cycles, want ack", k);
      end
      exp_idx = exp_q.pop_front();
      total++;
      if (k !== exp_k) begin
         bad++;
         $display("FAIL draw_latency: got %0d cycles want %0d", k, exp_k);
      end
      total++;
      if (player_ack !== exp_p || dealer_ack !== !exp_p) begin
         bad++;
         $display("FAIL draw_winner: got p=%0b d=%0b want p=%0b", player_ack, dealer_ack, exp_p);
      end
      total++;
      if (card_value !== 4'(int'(exp_idx) % 13 + 1) || card_symbol !== 2'(int'(exp_idx) / 13)) begin
         bad++;
         $display("FAIL draw_card: got v=%0d s=%0d want v=%0d s=%0d", card_value, card_symbol,
                  int'(exp_idx) % 13 + 1, int'(exp_idx) / 13);
      end
      total++;
      if (int'(cards_left) !== m_left - 1 || deck_empty !== (m_left == 1)) begin
         bad++;
         $display("FAIL draw_count: got left=%0d empty=%0b want left=%0d", cards_left, deck_empty, m_left - 1);
      end
      got_idx = int'(card_symbol) * 13 + int'(card_value) - 1;
      total++;
      if (got_idx < 0 || got_idx > 51 || m_seen[(got_idx < 0 || got_idx > 51) ? 0 : got_idx]) begin
         bad++;
         $display("FAIL draw_distinct: got index %0d, want an unused index", got_idx);
      end else begin
         m_seen[got_idx] = 1'b1;
      end
      m_used[idx] = 1'b1;
      m_left      = m_left - 1;
      m_last_p    = exp_p;
      held_val = card_value;
      held_sym = card_symbol;
      player_req = 1'b0;
      dealer_req = 1'b0;
      @(negedge clk);
      total++;
      if (player_ack !== 1'b0 || dealer_ack !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL after_grant: got p=%0b d=%0b busy=%0b want 0 0 0", player_ack, dealer_ack, busy);
      end
      total++;
      if (card_value !== held_val || card_symbol !== held_sym) begin
         bad++;
         $display("FAIL card_hold: got v=%0d s=%0d want v=%0d s=%0d", card_value, card_symbol, held_val, held_sym);
      end
   endtask

   task automatic test_reset();
      total++;
      if (cards_left !== 6'd52 || deck_empty !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_deck: got left=%0d empty=%0b busy=%0b want 52 0 0", cards_left, deck_empty, busy);
      end
      total++;
      if (player_ack !== 1'b0 || dealer_ack !== 1'b0 || card_value !== 4'd0 || card_symbol !== 2'd0) begin
         bad++;
         $display("FAIL reset_outputs: got p=%0b d=%0b v=%0d s=%0d want all 0", player_ack, dealer_ack, card_value, card_symbol);
      end
   endtask

   task automatic test_first_draw();
      do_draw(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_tie();
      do_draw(1'b1, 1'b1, 1'b0);
      do_draw(1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_random_draws(input int n);
      logic [2:0] pat;
      logic [3:0] v;
      for (int i = 0; i < n; i++) begin
         v = card_value;
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || card_value !== v) begin
               bad++;
               $display("FAIL gap_idle: got busy=%0b v=%0d want 0 %0d", busy, card_value, v);
            end
         end
         pat = 3'($urandom_range(1, 3));
         do_draw(pat[0], pat[1], ($urandom_range(0, 3) == 0));
      end
   endtask

   task automatic test_rank_wrap();
      test_random_draws(13 - (52 - m_left));
      do_draw(1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_empty_shuffle();
      logic acked;
      test_random_draws(m_left);
      total++;
      if (deck_empty !== 1'b1 || cards_left !== 6'd0) begin
         bad++;
         $display("FAIL empty_flag: got empty=%0b left=%0d want 1 0", deck_empty, cards_left);
      end
      player_req = 1'b1;
      acked = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (player_ack || dealer_ack) acked = 1'b1;
      end
      total++;
      if (acked !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL empty_no_ack: got acked=%0b busy=%0b want 0 0", acked, busy);
      end
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      total++;
      if (busy !== 1'b1 || player_ack !== 1'b0) begin
         bad++;
         $display("FAIL shuffle_clear: got busy=%0b ack=%0b want 1 0", busy, player_ack);
      end
      @(negedge clk);
      model_clear();
      total++;
      if (cards_left !== 6'd52 || deck_empty !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL shuffle_refill: got left=%0d empty=%0b busy=%0b want 52 0 0", cards_left, deck_empty, busy);
      end
      do_draw(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_draw();
      int   c;
      logic acked;
      player_req = 1'b1;
      @(negedge clk);
      c = int'(m_lfsr[5:0]);
`ifdef CARD_DRAW_FIXED_EN
      @(negedge clk);
`else
      if (!(c < 52 && !m_used[c])) @(negedge clk);
`endif
      acked = player_ack || dealer_ack;
      rst = 1'b1;
      #1;
      total++;
      if (acked !== 1'b0 || player_ack !== 1'b0 || busy !== 1'b0 || cards_left !== 6'd52) begin
         bad++;
         $display("FAIL abort_reset: got acked=%0b ack=%0b busy=%0b left=%0d want 0 0 0 52",
                  acked, player_ack, busy, cards_left);
      end
      @(negedge clk);
      player_req = 1'b0;
      rst = 1'b0;
      model_clear();
      m_last_p = 1'b0;
      acked = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (player_ack || dealer_ack) acked = 1'b1;
      end
      total++;
      if (acked !== 1'b0 || cards_left !== 6'd52 || deck_empty !== 1'b0) begin
         bad++;
         $display("FAIL abort_after: got acked=%0b left=%0d empty=%0b want 0 52 0", acked, cards_left, deck_empty);
      end
   endtask

   initial begin
      rst = 1'b1;
      shuffle = 1'b0;
      player_req = 1'b0;
      dealer_req = 1'b0;
      m_last_p = 1'b0;
      model_clear();
      do_reset();
      test_reset();
      test_first_draw();
      do_reset();
      test_tie();
      test_rank_wrap();
      test_empty_shuffle();
      test_reset_mid_draw();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/card_draw_ctrl.md
CARD_DRAW_CTRL -- requirements
Module: card_draw_ctrl

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1: initial LFSR state; a value of 0 SHALL be replaced by 16'h0001.
REQ-002 SHALL have port clk  input  1  posedge clock, sole clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port shuffle  input  1  pulse; return all 52 cards to the deck.
REQ-005 SHALL have port player_req  input  1  level; player requests one card, held until player_ack.
REQ-006 SHALL have port dealer_req  input  1  level; dealer requests one card, held until dealer_ack.
REQ-007 SHALL have port player_ack  output  1  one-cycle pulse; card outputs valid for player.
REQ-008 SHALL have port dealer_ack  output  1  one-cycle pulse; card outputs valid for dealer.
REQ-009 SHALL have port card_value  output  4  drawn card rank, 1..13.
REQ-010 SHALL have port card_symbol  output  2  drawn card suit, 0..3.
REQ-011 SHALL have port cards_left  output  6  undealt cards, 0..52.
REQ-012 SHALL have port deck_empty  output  1  high when cards_left==0.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL keep a 52-bit used mask; card index i maps to card_value=(i mod 13)+1 and card_symbol=i/13.
REQ-015 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every clock, independent of FSM state.
REQ-016 SHALL implement the FSM states IDLE, CLEAR, PICK, SCAN and GRANT.
REQ-017 IDLE: shuffle -> CLEAR; else any req with cards_left>0 -> PICK; else stay in IDLE.
REQ-018 shuffle SHALL take priority over a request in the same cycle and SHALL be ignored outside IDLE.
REQ-019 Arbitration on IDLE->PICK: a single requester wins; on simultaneous requests, the requester not granted last wins (round-robin); the winner SHALL be latched.
REQ-020 PICK: candidate c=lfsr[5:0]; if c<52 and unused -> GRANT with index c; otherwise -> SCAN starting at (c<52 ? c : c-52).
REQ-021 SCAN: each cycle, if the current index is unused -> GRANT, else index+1 with 51 wrapping to 0; termination is guaranteed because cards_left>0.
REQ-022 GRANT (one cycle): register card_value/card_symbol, set the mask bit, decrement cards_left, pulse the latched requester's ack, update last-granted, then -> IDLE.
REQ-023 Latency: req seen in IDLE at cycle N -> ack at N+2 (direct hit) or at most N+54 (SCAN worst case).
REQ-024 card_value/card_symbol SHALL hold their value until the next GRANT.
REQ-025 CLEAR (one cycle): zero the mask, set cards_left=52, deassert deck_empty, -> IDLE; card outputs unchanged.
REQ-026 With cards_left==0, requests SHALL get no ack and SHALL remain pending until a shuffle.
REQ-027 A request dropped before its ack SHALL NOT abort the draw; the latched requester is still acked and the card is consumed.
REQ-028 player_ack and dealer_ack SHALL never be high in the same cycle.

Reset
REQ-029 On rst: state=IDLE, mask=0, cards_left=52, deck_empty=0, busy=0, both acks=0, card_value=0, card_symbol=0, lfsr=LFSR_SEED, last-granted=dealer (player wins the first tie).
REQ-030 rst asserted mid-draw SHALL abort the draw immediately: no ack, no mask bit set.

Configuration
REQ-031 Macro CARD_DRAW_FIXED_EN: when defined, PICK SHALL always go to SCAN starting at index 0, so the deal is deterministic in lowest-unused-index order; when undefined, the LFSR behaviour of REQ-020 applies.

Verification (CARD_DRAW_FIXED_EN defined unless stated)
REQ-032 rst, then player_req -> player_ack after the scan, card_value=1, card_symbol=0, cards_left=51.
REQ-033 After reset, player_req and dealer_req raised together and held -> player acked first (value 1), then dealer (value 2); cards_left=50; acks never overlap.
REQ-034 Draw 13 cards, then dealer_req -> card_value=1, card_symbol=1 (index 13).
REQ-035 Draw 52 cards -> deck_empty=1, cards_left=0; a further player_req gets no ack; shuffle -> CLEAR, cards_left=52, the pending request is then served with card_value=1, card_symbol=0.
REQ-036 Macro undefined, LFSR_SEED=16'hACE1: 52 draws -> 52 distinct indices, each ack within 54 cycles of IDLE; rst asserted during SCAN -> no ack, cards_left returns to 52.
